// File: rtl/riscv_ifetch.sv
// Instruction fetch: PC sequencing, credit-limited imem requests, instruction buffer to decode; optional halt detect via RISCV_IFETCH_HALT_DETECT_EN.
// Latency: request accept at N, response at N+1 or later, id_valid one cycle after the response (no bypass).
// Backpressure: id_ready low fills the buffer; new requests stop once in-flight plus buffered words reach FIFO_DEPTH.
module riscv_ifetch #(
    parameter int                  DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0,
    parameter int                  FIFO_DEPTH      = 2,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic                  halted
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
    logic [FAW-1:0]        fifo_wr, fifo_rd;
    logic [CW-1:0]         fifo_cnt;
    logic [DATA_WIDTH-1:0] pend_pc    [MAX_OUTSTANDING];
    logic [PAW-1:0]        pend_wr, pend_rd;
    logic [OW-1:0]         outstanding, outstanding_nxt, drop_cnt;
    logic [DATA_WIDTH-1:0] last_instr, last_pc;
    logic                  req_fire, rsp_drop, push, pop, halt_hit, flush_pend, credit_ok;

    assign req_fire        = imem_req_valid & imem_req_ready;
    assign rsp_drop        = imem_rsp_valid & (drop_cnt != '0);
    assign push            = imem_rsp_valid & ~rsp_drop;
    assign pop             = id_valid & id_ready;
    assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
    assign credit_ok       = (32'(outstanding) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH);

`ifdef RISCV_IFETCH_HALT_DETECT_EN
    localparam logic [DATA_WIDTH-1:0] HALT_WORD = DATA_WIDTH'(32'h0000_006F);
    assign halt_hit = push & (state == RUN) & (imem_rsp_data == HALT_WORD);
`else
    assign halt_hit = 1'b0;
`endif
    // Entering HALT also turns every request still in flight into a drop.
    assign flush_pend = redirect_valid | halt_hit;

    assign imem_req_addr = fetch_pc;
    assign id_valid      = (fifo_cnt != '0);
    assign id_instr      = id_valid ? fifo_instr[fifo_rd] : last_instr;
    assign id_pc         = id_valid ? fifo_pc[fifo_rd]    : last_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = redirect_valid ? RUN : (halt_hit ? HALT : RUN);
            HALT:    state_nxt = redirect_valid ? RUN : HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == RUN) & ~redirect_valid &
                         (outstanding < OW'(MAX_OUTSTANDING)) & credit_ok;
`ifdef RISCV_IFETCH_HALT_DETECT_EN
        halted = (state == HALT) & (fifo_cnt == '0) & (outstanding == '0);
`else
        halted = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_cnt    <= '0;
            pend_wr     <= '0;
            pend_rd     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            last_instr  <= '0;
            last_pc     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid)
                fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + DATA_WIDTH'(4);

            if (flush_pend) begin
                drop_cnt <= outstanding_nxt;
                pend_wr  <= '0;
                pend_rd  <= '0;
            end else begin
                if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
                if (req_fire) pend_wr <= (pend_wr == PAW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wr + PAW'(1);
                if (push)     pend_rd <= (pend_rd == PAW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rd + PAW'(1);
            end

            // A handshake in the redirect cycle still counts; the flush just discards the rest.
            if (redirect_valid) begin
                fifo_wr  <= '0;
                fifo_rd  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) fifo_wr <= fifo_wr + FAW'(1);
                if (pop)  fifo_rd <= fifo_rd + FAW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end

            if (id_valid) begin
                last_instr <= id_instr;
                last_pc    <= id_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
        end
        if (req_fire) pend_pc[pend_wr] <= fetch_pc;
    end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Randomized scoreboard bench for riscv_ifetch: imem model with random in-order latency, PC-stream reference model.
module tb_riscv_ifetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic        halted;

    riscv_ifetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          max_delay = 1, rdy_pct = 100, idr_pct = 100;
    bit          halt_mode = 0, halt_pending = 0, found;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_in_q[$];
    rsp_t        rspq[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        if (halt_mode && a == 32'h20) return 32'h0000_006F;
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        redirect_valid = 1'b0;
    endtask

    // imem model: in-order responses, each no earlier than its own random due cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        if (rspq.size() > 0 && rspq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(rspq[0].addr);
            void'(rspq.pop_front());
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid && imem_req_valid) chk("req_in_redirect_cycle", 32'(imem_req_valid), 32'h0);
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, model_pc);
                rspq.push_back('{imem_req_addr, cyc + int'($urandom_range(max_delay, 1))});
                if (!halt_pending) begin
                    exp_pc_q.push_back(model_pc);
                    exp_in_q.push_back(word(model_pc));
                    if (halt_mode && model_pc == 32'h20) halt_pending = 1;
                end
                model_pc = model_pc + 32'd4;
            end
            if (id_valid && id_ready) begin
                if (exp_pc_q.size() == 0) begin
                    chk("unexpected_delivery_pc", id_pc, 32'hDEAD_BEEF);
                end else begin
                    chk("id_pc", id_pc, exp_pc_q.pop_front());
                    chk("id_instr", id_instr, exp_in_q.pop_front());
                end
            end
            if (redirect_valid) begin
                exp_pc_q.delete();
                exp_in_q.delete();
                model_pc     = {redirect_pc[31:2], 2'b00};
                halt_pending = 0;
            end
`ifndef RISCV_IFETCH_HALT_DETECT_EN
            chk("halted_tied_low", 32'(halted), 32'h0);
`endif
        end
    end

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        rst_n = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
        #1 chk("idle_no_req", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'h1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("id_not_in_rsp_cycle", 32'(id_valid), 32'h0);
        @(negedge clk);
        chk("first_id_valid", 32'(id_valid), 32'h1);
        chk("first_id_pc", id_pc, 32'h0);
        chk("first_id_instr", id_instr, word(32'h0));

        rdy_pct = 70; idr_pct = 70; max_delay = 3;
        repeat (200) step();

        rdy_pct = 100; idr_pct = 0;
        repeat (10) step();
        @(negedge clk);
        chk("stall_no_req", 32'(imem_req_valid), 32'h0);
        chk("stall_held_words", 32'(exp_pc_q.size()), 32'd2);
        chk("stall_id_valid", 32'(id_valid), 32'h1);
        idr_pct = 100;
        repeat (20) step();

        found = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            #1;
            if (rspq.size() >= 2) begin found = 1; break; end
        end
        chk("two_outstanding_seen", 32'(found), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id_valid) break;
        end
        chk("redirect_first_pc", id_pc, 32'h100);
        repeat (20) step();

        for (int i = 0; i < 50; i++) begin
            step();
            if (id_valid) begin
                redirect_valid = 1'b1; redirect_pc = 32'h200;
                break;
            end
        end
        step();
        @(negedge clk);
        chk("flush_empty_after_redirect", 32'(id_valid), 32'h0);
        repeat (20) step();

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        repeat (20) step();

        rdy_pct = 70; idr_pct = 70;
        repeat (300) begin
            step();
            if ($urandom_range(99) < 5) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
        end

`ifdef RISCV_IFETCH_HALT_DETECT_EN
        rdy_pct = 100; idr_pct = 100; max_delay = 1; halt_mode = 1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            @(negedge clk);
            if (halted) begin found = 1; break; end
        end
        chk("halt_reached", 32'(found), 32'h1);
        chk("halt_all_delivered", 32'(exp_pc_q.size()), 32'd0);
        repeat (5) begin
            step();
            @(negedge clk);
            chk("halt_no_req", 32'(imem_req_valid), 32'h0);
            chk("halt_stays", 32'(halted), 32'h1);
        end
        halt_mode = 0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        @(negedge clk);
        chk("halt_cleared", 32'(halted), 32'h0);
        repeat (20) step();
`endif

        rdy_pct = 0; idr_pct = 100;
        repeat (20) step();
        @(negedge clk);
        chk("drained_no_lost_words", 32'(exp_pc_q.size()), 32'd0);
        chk("drained_id_valid", 32'(id_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
